// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: four selectable patterns (rotate left/right, ping-pong, blink)
// stepped at a base tick rate divided by 1, 2 or 4, with a hold input that freezes stepping.
module led_seq_ctrl #(
    parameter int TICK_MAX = 24_999_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_req,
    input  logic       speed_req,
    input  logic       hold,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed
);

    localparam logic [1:0] ROT_L = 2'b00;
    localparam logic [1:0] ROT_R = 2'b01;
    localparam logic [1:0] PING  = 2'b10;
    localparam logic [1:0] BLINK = 2'b11;

    localparam logic [27:0] TICK_LAST = 28'(TICK_MAX);

    logic [27:0] cnt_q, cnt_d;
    logic [1:0]  div_q, div_d;
    logic [1:0]  speed_q, speed_d;
    logic [1:0]  mode_q, mode_d;
    logic [3:0]  led_q, led_d;
    logic [1:0]  pos_q, pos_d;
    logic        dir_q, dir_d;

    logic        tick;
    logic        step;
    logic [1:0]  divLast;
    logic [1:0]  pingPos;

    always_comb begin
        unique case (speed_q)
            2'd0:    divLast = 2'd0;
            2'd1:    divLast = 2'd1;
            default: divLast = 2'd3;
        endcase
    end

    assign tick    = (cnt_q == TICK_LAST) && !hold;
    assign step    = tick && (div_q == divLast);
    assign pingPos = dir_q ? pos_q + 2'd1 : pos_q - 2'd1;

    // A mode request wins over a simultaneous step: the new pattern starts fresh from its initial value.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        speed_d = speed_q;
        mode_d  = mode_q;
        led_d   = led_q;
        pos_d   = pos_q;
        dir_d   = dir_q;

        if (!hold) begin
            cnt_d = (cnt_q == TICK_LAST) ? 28'd0 : cnt_q + 28'd1;
        end

        if (step) begin
            div_d = 2'd0;
        end else if (tick) begin
            div_d = div_q + 2'd1;
        end

        if (speed_req) begin
            speed_d = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
            div_d   = 2'd0;
        end

        if (mode_req) begin
            mode_d = mode_q + 2'd1;
            cnt_d  = 28'd0;
            div_d  = 2'd0;
            pos_d  = 2'd0;
            dir_d  = 1'b1;
            unique case (mode_d)
                ROT_L:   led_d = 4'b1110;
                ROT_R:   led_d = 4'b0111;
                PING:    led_d = 4'b1110;
                default: led_d = 4'b0000;
            endcase
        end else if (step) begin
            unique case (mode_q)
                ROT_L: led_d = {led_q[2:0], led_q[3]};
                ROT_R: led_d = {led_q[0], led_q[3:1]};
                PING: begin
                    pos_d = pingPos;
                    led_d = ~(4'b0001 << pingPos);
                    if (pingPos == 2'd3) begin
                        dir_d = 1'b0;
                    end else if (pingPos == 2'd0) begin
                        dir_d = 1'b1;
                    end
                end
                default: led_d = ~led_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 28'd0;
            div_q   <= 2'd0;
            speed_q <= 2'd0;
            mode_q  <= ROT_L;
            led_q   <= 4'b1110;
            pos_q   <= 2'd0;
            dir_q   <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            speed_q <= speed_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign speed = speed_q;

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_MAX, default 24_999_999, meaning the base tick is one cycle in every TICK_MAX+1 clk cycles (500 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1 bit, system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 SHALL have port mode_req, input, 1 bit, single-cycle pulse that advances the pattern mode (pre-debounced).
REQ-005 SHALL have port speed_req, input, 1 bit, single-cycle pulse that advances the speed level (pre-debounced).
REQ-006 SHALL have port hold, input, 1 bit, level signal; while high, pattern advance is frozen.
REQ-007 SHALL have port led, output, 4 bits, registered and active-low LED drive.
REQ-008 SHALL have port mode, output, 2 bits, registered current mode: 00 ROT_L, 01 ROT_R, 10 PING, 11 BLINK.
REQ-009 SHALL have port speed, output, 2 bits, registered current speed level, 0..2.

Function
REQ-010 The base counter cnt SHALL count 0..TICK_MAX and wrap to 0; tick = (cnt==TICK_MAX) and !hold.
REQ-011 cnt SHALL be 28 bits wide; it SHALL hold its value while hold=1.
REQ-012 The divider div SHALL increment on each tick; step = tick and (div == 2^speed - 1); div SHALL clear on step.
REQ-013 The resulting step period SHALL be (TICK_MAX+1)*2^speed cycles.
REQ-014 Each speed_req SHALL advance speed 0->1->2->0 and clear div; cnt SHALL be unaffected.
REQ-015 Each mode_req SHALL advance mode 00->01->10->11->00 and, on the same edge, clear cnt and div and load the new mode's initial led value.
REQ-016 Initial led values SHALL be: ROT_L 1110, ROT_R 0111, PING 1110 with dir=up, BLINK 0000.
REQ-017 On step in ROT_L, led SHALL become {led[2:0],led[3]}.
REQ-018 On step in ROT_R, led SHALL become {led[0],led[3:1]}.
REQ-019 On step in PING, the single zero SHALL move at position pos, with led = ~(1<<pos).
REQ-020 PING pos SHALL follow the sequence 0,1,2,3,2,1,0,1,...; at pos 3, dir SHALL become down; at pos 0, dir SHALL become up; there SHALL be no repeat at either end.
REQ-021 On step in BLINK, led SHALL become ~led.
REQ-022 When mode_req and step occur in the same cycle, mode_req SHALL take priority: the initial pattern is loaded and no step is applied.
REQ-023 When mode_req and speed_req occur in the same cycle, both SHALL be applied.
REQ-024 When mode_req occurs while hold=1, the mode change and pattern load SHALL still occur, and the counters SHALL remain frozen at 0 until hold falls.
REQ-025 When speed_req and step occur in the same cycle, the step SHALL apply and speed SHALL advance.
REQ-026 No output SHALL change except at the edges defined above; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 On rst_n low, the block SHALL set immediately, regardless of clk: led=1110, mode=00, speed=0, cnt=0, div=0, PING dir=up.
REQ-028 A reset asserted mid-operation SHALL abandon the current pattern without completing the current step.
REQ-029 The first step after reset release SHALL occur TICK_MAX+1 cycles after the first active edge.

Verification (TICK_MAX=3)
REQ-030 Reset release with idle inputs -> led 1110, 1101, 1011, 0111, 1110, changing every 4 cycles.
REQ-031 One mode_req -> mode=01 and led=0111 on the next edge, then 1011, 1101, 1110 every 4 cycles.
REQ-032 Two mode_req pulses -> PING: 1110, 1101, 1011, 0111, 1011, 1101, 1110, 1101 every 4 cycles.
REQ-033 speed_req x1 -> steps every 8 cycles; x2 -> every 16 cycles; x3 -> speed=0 and steps every 4 cycles; also mode_req+speed_req in the same cycle -> both advance.
REQ-034 hold high for 20 cycles starting at cnt=2 -> led constant; after release, next step after 2 cycles.
REQ-035 BLINK mode toggling 0000/1111, with rst_n pulsed low between edges -> led=1110 and mode=00 before the next clk edge.
